// File: rtl/mor1kx_dmmu_reload_arb.sv
// Data-bus arbiter between the LSU and the DMMU page-table walker.
// Optional reload watchdog enabled by defining MOR1KX_DBUS_RELOAD_TIMEOUT_EN.
module mor1kx_dmmu_reload_arb #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tlb_reload_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] tlb_reload_addr_i,
  output logic                            tlb_reload_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] tlb_reload_data_o,
  output logic                            tlb_reload_err_o,
  input  logic                            lsu_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lsu_dat_i,
  input  logic                            lsu_we_i,
  input  logic [3:0]                      lsu_bsel_i,
  output logic                            lsu_ack_o,
  output logic                            lsu_err_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] lsu_dat_o,
  output logic                            dbus_req_o,
  output logic                            dbus_we_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dbus_adr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_o,
  output logic [3:0]                      dbus_bsel_o,
  input  logic                            dbus_ack_i,
  input  logic                            dbus_err_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] dbus_dat_i
);

  typedef enum logic [1:0] {IDLE, LSU, RELOAD, GAP} state_t;

  state_t state_q, state_d;
  logic   grant_reload, grant_lsu;
  logic   bus_ack, bus_err, timeout;
  logic   reload_done, reload_fail;

  // Bus responses only count while a request is outstanding; err beats ack.
  assign bus_err = dbus_req_o & dbus_err_i;
  assign bus_ack = dbus_req_o & dbus_ack_i & ~dbus_err_i;

`ifdef MOR1KX_DBUS_RELOAD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt_q;

  // Counter reads N-1 on the Nth RELOAD cycle, so the watchdog fires on that cycle.
  assign timeout = (state_q == RELOAD) && (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 to_cnt_q <= '0;
    else if (state_q != RELOAD) to_cnt_q <= '0;
    else                        to_cnt_q <= to_cnt_q + CW'(1);
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  assign reload_done = (state_q == RELOAD) & (bus_ack | bus_err | timeout);
  assign reload_fail = (state_q == RELOAD) & (bus_err | timeout);

  assign tlb_reload_ack_o  = reload_done;
  assign tlb_reload_err_o  = reload_fail;
  assign tlb_reload_data_o = (reload_done & ~reload_fail) ? dbus_dat_i : '0;

  // A requester that has already let go of lsu_req_i never sees its completion.
  assign lsu_ack_o = (state_q == LSU) & lsu_req_i & bus_ack;
  assign lsu_err_o = (state_q == LSU) & lsu_req_i & bus_err;
  assign lsu_dat_o = dbus_dat_i;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    grant_reload = 1'b0;
    grant_lsu    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tlb_reload_req_i) begin
          state_d      = RELOAD;
          grant_reload = 1'b1;
        end else if (lsu_req_i) begin
          state_d   = LSU;
          grant_lsu = 1'b1;
        end
      end
      LSU:    if (bus_ack | bus_err) state_d = IDLE;
      RELOAD: if (reload_done) state_d = GAP;
      GAP: begin
        if (tlb_reload_req_i) begin
          state_d      = RELOAD;
          grant_reload = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dbus_req_o  <= 1'b0;
      dbus_we_o   <= 1'b0;
      dbus_adr_o  <= '0;
      dbus_dat_o  <= '0;
      dbus_bsel_o <= 4'h0;
    end else begin
      state_q    <= state_d;
      dbus_req_o <= (state_d == LSU) || (state_d == RELOAD);
      if (grant_reload) begin
        dbus_we_o   <= 1'b0;
        dbus_adr_o  <= tlb_reload_addr_i;
        dbus_dat_o  <= '0;
        dbus_bsel_o <= 4'hf;
      end else if (grant_lsu) begin
        dbus_we_o   <= lsu_we_i;
        dbus_adr_o  <= lsu_adr_i;
        dbus_dat_o  <= lsu_dat_i;
        dbus_bsel_o <= lsu_bsel_i;
      end
    end
  end

endmodule

// File: doc/mor1kx_dmmu_reload_arb.md
# mor1kx_dmmu_reload_arb

Data-bus arbiter directly downstream of the data MMU's hardware TLB reload port. It grants the single data bus to either the LSU or the DMMU page-table walker. It sequences the walker's two back-to-back reads (PTE pointer, then PTE) with an address-settling gap between them. Bus errors are converted into the all-zero response the walker already treats as a page fault.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, address/data width
- TIMEOUT_CYCLES, 255, reload watchdog limit (used only with the macro below)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- tlb_reload_req_i  in  1  walker request, held across both reads
- tlb_reload_addr_i  in  W  walker read address
- tlb_reload_ack_o  out  1  walker read done (combinational)
- tlb_reload_data_o  out  W  walker read data, valid with ack
- tlb_reload_err_o  out  1  walker read failed (with ack)
- lsu_req_i  in  1  LSU request, held until ack/err
- lsu_adr_i, lsu_dat_i  in  W  LSU address, write data
- lsu_we_i  in  1  LSU write
- lsu_bsel_i  in  4  LSU byte select
- lsu_ack_o, lsu_err_o  out  1  LSU completion (combinational)
- lsu_dat_o  out  W  LSU read data (dbus_dat_i passthrough)
- dbus_req_o, dbus_we_o  out  1  bus request, write (registered)
- dbus_adr_o, dbus_dat_o  out  W  bus address, write data (registered)
- dbus_bsel_o  out  4  bus byte select (registered)
- dbus_ack_i, dbus_err_i  in  1  bus completion
- dbus_dat_i  in  W  bus read data

## Operation
- States: IDLE, LSU, RELOAD, GAP.
- IDLE: tlb_reload_req_i → RELOAD, latch tlb_reload_addr_i, we=0, bsel=4'hf. Else lsu_req_i → LSU, latch all lsu_* fields. Reload wins simultaneous requests.
- LSU: dbus_req_o=1. On dbus_ack_i or dbus_err_i: lsu_ack_o or lsu_err_o = that input, same cycle. Next state IDLE, dbus_req_o=0. An early drop of lsu_req_i does not abort the transfer; its completion is discarded.
- RELOAD: dbus_req_o=1, we=0. dbus_ack_i → tlb_reload_ack_o=1, tlb_reload_data_o=dbus_dat_i. dbus_err_i → tlb_reload_ack_o=1, tlb_reload_err_o=1, tlb_reload_data_o=0, so the walker faults. Both go to GAP.
- GAP: dbus_req_o=0 for one cycle while the walker updates its address. tlb_reload_req_i still high → RELOAD and latch the new address. Otherwise → IDLE.
- tlb_reload_data_o is 0 whenever tlb_reload_ack_o=0. lsu_ack_o/lsu_err_o are 0 outside LSU.
- Bus contract: the slave abandons a transfer when dbus_req_o drops. dbus_ack_i/dbus_err_i are ignored while dbus_req_o=0. If ack and err arrive together, err wins.

## Timing
- Reset values: all outputs 0; state IDLE; latched fields 0. Reset mid-transfer drops dbus_req_o immediately (asynchronous).
- Grant latency: request sampled in IDLE at edge N → dbus_req_o=1 after edge N.
- Completion: requester ack/err are in the same cycle as dbus_ack_i/dbus_err_i; dbus_req_o=0 after that edge.
- Zero-wait bus: LSU access takes 2 cycles (grant + ack). A full two-read walk takes 5 cycles (grant, ack, GAP, ack, GAP).
- An LSU request arriving during RELOAD/GAP waits until IDLE. A reload request arriving during LSU waits for LSU completion plus one IDLE cycle.

## Configuration
- Macro MOR1KX_DBUS_RELOAD_TIMEOUT_EN.
- Defined: a counter of width $clog2(TIMEOUT_CYCLES+1) clears on RELOAD entry and increments each RELOAD cycle without ack/err. When it reaches TIMEOUT_CYCLES, that cycle behaves as dbus_err_i: tlb_reload_ack_o=1, tlb_reload_err_o=1, data 0, then → GAP. LSU transfers are never timed.
- Undefined: no counter; RELOAD waits indefinitely; TIMEOUT_CYCLES ignored.

## Test plan
- Reset mid-RELOAD (dbus_req_o=1): assert rst_n=0 → dbus_req_o=0 with no clock edge; after release, state IDLE and all outputs 0.
- LSU read to 0x0000_1000, dbus_ack_i one cycle after request with dat 0xDEAD_BEEF → lsu_ack_o=1 and lsu_dat_o=0xDEAD_BEEF in the same cycle; dbus_req_o low the next cycle.
- Walker pointer read at 0x0040_0004 returns 0x0012_2000. Walker changes address to 0x0012_2008 after the ack. → GAP cycle with dbus_req_o=0, then a second read at 0x0012_2008; 5 cycles total on a zero-wait bus.
- lsu_req_i and tlb_reload_req_i rise in the same cycle → walker granted first; LSU granted only after the walker's final GAP → IDLE.
- Walker read with dbus_err_i=1 and dbus_dat_i=0xFFFF_FFFF → tlb_reload_ack_o=1, tlb_reload_err_o=1, tlb_reload_data_o=0.
- With the macro defined and TIMEOUT_CYCLES=8, no bus response → ack+err on the 8th RELOAD cycle without response; with the macro undefined, the request stays pending after 1000 cycles.
